roic_readout_decoder: RTL and testbench

- Receive-side counterpart of the ROIC shift-based scanner. Watches the scanner's one-hot row/column enables plus the sampled pixel value.
- Converts each enabled pixel into a binary-addressed pixel beat (row, col, data) with frame/line markers.
- Checks that the scan order and one-hot integrity are correct. Sits between the scanner and the downstream frame buffer/DMA.

---
 rtl/roic_pkg.sv | 15 +
 rtl/roic_onehot_enc.sv | 31 +++
 rtl/roic_readout_decoder.sv | 149 ++++++++++++++
 tb/tb_roic_readout_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/roic_pkg.sv
// Shared sizes and enums for the ROIC readout decoder: scanner geometry defaults,
// decoder FSM states and one-hot vector classification.
package roic_pkg;

   localparam int DEF_N_COLS = 640;
   localparam int DEF_N_ROWS = 512;
   localparam int DEF_DATA_W = 14;
   localparam int DEF_COL_W  = $clog2(DEF_N_COLS);
   localparam int DEF_ROW_W  = $clog2(DEF_N_ROWS);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

   typedef enum logic [1:0] {NONE, ONE, MULTI} cls_t;

endpackage

// File: rtl/roic_onehot_enc.sv
// One-hot to binary encoder with zero/one/multi classification of the input vector.
// Purely combinational (0 clk); no backpressure.
module roic_onehot_enc
   import roic_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output cls_t         cls
);

   logic [N-1:0] vec_m1;

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = idx | W'(i);
      end
      // Clearing the lowest set bit leaves something only when two or more bits are set.
      vec_m1 = vec - N'(1);
      if (vec == '0)
         cls = NONE;
      else if ((vec & vec_m1) != '0)
         cls = MULTI;
      else
         cls = ONE;
   end

endmodule

// File: rtl/roic_readout_decoder.sv
// Turns the scanner's one-hot row/column enables into binary-addressed pixel beats with
// sof/eol/eof markers and scan-order checks. Latency 2 clk; no backpressure, beats follow the scanner.
module roic_readout_decoder
   import roic_pkg::*;
#(
   parameter int N_COLS = DEF_N_COLS,
   parameter int N_ROWS = DEF_N_ROWS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int COL_W  = $clog2(N_COLS),
   parameter int ROW_W  = $clog2(N_ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_COLS-1:0] col_enable,
   input  logic [N_ROWS-1:0] row_enable,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              scan_done,
   output logic              pix_valid,
   output logic [ROW_W-1:0]  pix_row,
   output logic [COL_W-1:0]  pix_col,
   output logic [DATA_W-1:0] pix_data,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic [15:0]       frame_cnt,
   output logic              err_onehot,
   output logic              err_seq
);

   logic [N_COLS-1:0] col_q;
   logic [N_ROWS-1:0] row_q;
   logic [DATA_W-1:0] pix_q;
   logic              sd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
         pix_q <= '0;
         sd_q  <= 1'b0;
      end else begin
         col_q <= col_enable;
         row_q <= row_enable;
         pix_q <= pix_in;
         sd_q  <= scan_done;
      end
   end

   logic [COL_W-1:0] col_idx;
   logic [ROW_W-1:0] row_idx;
   cls_t             col_cls;
   cls_t             row_cls;

   roic_onehot_enc #(.N(N_COLS), .W(COL_W)) u_col_enc (.vec(col_q), .idx(col_idx), .cls(col_cls));
   roic_onehot_enc #(.N(N_ROWS), .W(ROW_W)) u_row_enc (.vec(row_q), .idx(row_idx), .cls(row_cls));

   state_t           state;
   logic [COL_W-1:0] exp_col;
   logic [ROW_W-1:0] exp_row;
   logic [COL_W-1:0] last_col;
   logic [ROW_W-1:0] last_row;
   logic             last_vld;
   logic             sd_prev;

   logic             active, multi, dwell, new_pix, origin, col_last, frame_last;
   logic             in_seq, sd_rise, start, emit;
   logic [COL_W-1:0] nxt_col;
   logic [ROW_W-1:0] nxt_row;

   always_comb begin
      active     = (col_cls == ONE) && (row_cls == ONE);
      multi      = (col_cls == MULTI) || (row_cls == MULTI);
      // A scanner dwelling on one pixel repeats its address; only the first cycle counts.
      dwell      = last_vld && (col_idx == last_col) && (row_idx == last_row);
      new_pix    = active && !dwell;
      origin     = (col_idx == '0) && (row_idx == '0);
      col_last   = (col_idx == COL_W'(N_COLS - 1));
      frame_last = col_last && (row_idx == ROW_W'(N_ROWS - 1));
      in_seq     = (col_idx == exp_col) && (row_idx == exp_row);
      nxt_col    = col_last ? '0 : col_idx + 1'b1;
      nxt_row    = col_last ? row_idx + 1'b1 : row_idx;
      sd_rise    = sd_q && !sd_prev;
      start      = new_pix && origin && ((state == SYNC) || (state == DONE));
      emit       = start || (new_pix && (state == ACTIVE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         exp_col    <= '0;
         exp_row    <= '0;
         last_col   <= '0;
         last_row   <= '0;
         last_vld   <= 1'b0;
         sd_prev    <= 1'b0;
         pix_valid  <= 1'b0;
         pix_row    <= '0;
         pix_col    <= '0;
         pix_data   <= '0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         frame_cnt  <= '0;
         err_onehot <= 1'b0;
         err_seq    <= 1'b0;
      end else begin
         pix_valid <= emit;
         sof       <= start;
         eol       <= emit && col_last;
         eof       <= 1'b0;
         sd_prev   <= sd_q;
         last_vld  <= active;
         if (active) begin
            last_col <= col_idx;
            last_row <= row_idx;
         end
         if (multi) err_onehot <= 1'b1;
         if (emit) begin
            pix_row  <= row_idx;
            pix_col  <= col_idx;
            pix_data <= pix_q;
            // Expected address always follows the last emitted beat, which resyncs after a skip.
            exp_col  <= nxt_col;
            exp_row  <= nxt_row;
         end

         case (state)
            IDLE: state <= SYNC;
            SYNC: if (start) state <= ACTIVE;
            ACTIVE: begin
               if (new_pix) begin
                  if (!in_seq) err_seq <= 1'b1;
                  if (frame_last) begin
                     eof       <= 1'b1;
                     frame_cnt <= frame_cnt + 16'd1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (start)        state <= ACTIVE;
               else if (sd_rise) state <= SYNC;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_roic_readout_decoder.sv
// Directed bench for roic_readout_decoder on an 8x4 array with a linear-index behavioural model.
module tb_roic_readout_decoder;

   localparam int NC   = 8;
   localparam int NR   = 4;
   localparam int DW   = 14;
   localparam int CW   = 3;
   localparam int RW   = 2;
   localparam int NPIX = NC * NR;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] col_enable;
   logic [NR-1:0] row_enable;
   logic [DW-1:0] pix_in;
   logic          scan_done;
   logic          pix_valid;
   logic [RW-1:0] pix_row;
   logic [CW-1:0] pix_col;
   logic [DW-1:0] pix_data;
   logic          sof, eol, eof;
   logic [15:0]   frame_cnt;
   logic          err_onehot, err_seq;

   always #5 clk = ~clk;

   roic_readout_decoder #(
      .N_COLS(NC), .N_ROWS(NR), .DATA_W(DW), .COL_W(CW), .ROW_W(RW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .col_enable(col_enable), .row_enable(row_enable),
      .pix_in(pix_in), .scan_done(scan_done), .pix_valid(pix_valid), .pix_row(pix_row),
      .pix_col(pix_col), .pix_data(pix_data), .sof(sof), .eol(eol), .eof(eof),
      .frame_cnt(frame_cnt), .err_onehot(err_onehot), .err_seq(err_seq)
   );

   typedef struct {
      bit vld; int row; int col; int data;
      bit sof; bit eol; bit eof;
      int fc; bit eoh; bit esq;
   } exp_t;

   exp_t slot [16];
   bit   slot_v [16];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   beats = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, cnt13 = 0;

   // Model: 0 = hunting for (0,0), 1 = inside a frame, 2 = frame finished.
   int m_mode, m_exp, m_last_pos, m_fc;
   bit m_last_v, m_prev_sd, m_eoh, m_esq;

   function automatic exp_t quiet_rec();
      exp_t e;
      e.vld = 0; e.row = 0; e.col = 0; e.data = 0;
      e.sof = 0; e.eol = 0; e.eof = 0;
      e.fc = m_fc; e.eoh = m_eoh; e.esq = m_esq;
      return e;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_exp = 0; m_last_pos = 0; m_fc = 0;
      m_last_v = 0; m_prev_sd = 0; m_eoh = 0; m_esq = 0;
   endtask

   task automatic model_step(input logic [NC-1:0] c, input logic [NR-1:0] r,
                             input int d, input bit sd, output exp_t e);
      int cc, cr, pos;
      bit rise;
      e = quiet_rec();
      rise = sd && !m_prev_sd;
      m_prev_sd = sd;
      cc = 0; cr = 0;
      for (int i = 0; i < NC; i++) if (c[i]) cc = i;
      for (int i = 0; i < NR; i++) if (r[i]) cr = i;
      pos = cr * NC + cc;
      if ($countones(c) > 1 || $countones(r) > 1) begin
         m_eoh = 1; m_last_v = 0;
      end else if (c == '0 || r == '0) begin
         m_last_v = 0;
      end else begin
         if (!(m_last_v && pos == m_last_pos)) begin
            if (m_mode == 1 || pos == 0) begin
               e.vld = 1; e.row = cr; e.col = cc; e.data = d;
               e.eol = (cc == NC - 1);
               if (m_mode != 1) begin
                  e.sof = 1; m_mode = 1;
               end else if (pos != m_exp) begin
                  m_esq = 1;
               end
               m_exp = pos + 1;
               if (pos == NPIX - 1) begin
                  e.eof = 1; m_fc = (m_fc + 1) % 65536; m_mode = 2;
               end
            end
         end
         m_last_v = 1; m_last_pos = pos;
      end
      if (m_mode == 2 && !e.vld && rise) m_mode = 0;
      e.fc = m_fc; e.eoh = m_eoh; e.esq = m_esq;
   endtask

   task automatic chk(input string nm, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic drive_now(input logic [NC-1:0] c, input logic [NR-1:0] r, input int d, input bit sd);
      exp_t e;
      col_enable = c; row_enable = r; pix_in = DW'(d); scan_done = sd;
      model_step(c, r, d, sd, e);
      slot[(cyc + 2) % 16]   = e;
      slot_v[(cyc + 2) % 16] = 1;
   endtask

   task automatic drive(input logic [NC-1:0] c, input logic [NR-1:0] r, input int d, input bit sd);
      @(negedge clk);
      drive_now(c, r, d, sd);
   endtask

   task automatic idle(input int n);
      repeat (n) drive('0, '0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      col_enable = '0; row_enable = '0; pix_in = '0; scan_done = 0;
      #1;
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_flags", int'({sof, eol, eof}), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_errors", int'({err_onehot, err_seq}), 0);
      chk("rst_addr_data", int'({pix_row, pix_col, pix_data}), 0);
      model_reset();
      slot[(cyc + 1) % 16] = quiet_rec(); slot_v[(cyc + 1) % 16] = 1;
      slot[(cyc + 2) % 16] = quiet_rec(); slot_v[(cyc + 2) % 16] = 1;
      @(negedge clk);
      rst_n = 1;
      drive_now('0, '0, 0, 0);
   endtask

   // One scanner frame in raster order; pix_in carries the linear index (row*8+col).
   task automatic frame(input int skip_p, input int dwell_p, input int multi_p,
                        input int stop_p, input bit lat);
      for (int p = 0; p < NPIX; p++) begin
         logic [NC-1:0] cv;
         logic [NR-1:0] rv;
         if (p == stop_p) return;
         cv = NC'(1 << (p % NC));
         rv = NR'(1 << (p / NC));
         if (p == multi_p) drive(8'b0001_0100, rv, 999, 0);
         if (p != skip_p) begin
            drive(cv, rv, p, 0);
            if (p == dwell_p) repeat (2) drive(cv, rv, p + 100, 0);
         end
         if (lat && p == 1) chk("lat_1clk_no_beat", int'(pix_valid), 0);
         if (lat && p == 2) chk("lat_2clk_sof_beat", int'({pix_valid, sof, pix_row, pix_col}), 'b1100000);
      end
   endtask

   initial begin : compare
      int k;
      exp_t e;
      bit bad;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         k = cyc % 16;
         if (slot_v[k]) begin
            slot_v[k] = 0;
            e = slot[k];
            bad = (pix_valid !== e.vld) || (sof !== e.sof) || (eol !== e.eol) || (eof !== e.eof) ||
                  (frame_cnt !== 16'(e.fc)) || (err_onehot !== e.eoh) || (err_seq !== e.esq);
            if (e.vld && ((pix_row !== RW'(e.row)) || (pix_col !== CW'(e.col)) || (pix_data !== DW'(e.data))))
               bad = 1;
            tests++;
            if (bad) begin
               fails++;
               $display("FAIL cycle_check cyc=%0d got vld=%0b r=%0d c=%0d d=%0d sof=%0b eol=%0b eof=%0b fc=%0d eoh=%0b esq=%0b; want vld=%0b r=%0d c=%0d d=%0d sof=%0b eol=%0b eof=%0b fc=%0d eoh=%0b esq=%0b",
                        cyc, pix_valid, pix_row, pix_col, pix_data, sof, eol, eof, frame_cnt, err_onehot, err_seq,
                        e.vld, e.row, e.col, e.data, e.sof, e.eol, e.eof, e.fc, e.eoh, e.esq);
            end
         end
         if (pix_valid) begin
            beats++;
            if (sof) sof_cnt++;
            if (eol) eol_cnt++;
            if (eof) eof_cnt++;
            if (pix_row == 2'd1 && pix_col == 3'd3) cnt13++;
         end
      end
   end

   initial begin : stim
      int b0, c13;
      rst_n = 0;
      col_enable = '0; row_enable = '0; pix_in = '0; scan_done = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("init_pix_valid", int'(pix_valid), 0);
      chk("init_frame_cnt", int'(frame_cnt), 0);
      chk("init_errors", int'({err_onehot, err_seq}), 0);
      @(negedge clk);
      rst_n = 1;
      drive_now('0, '0, 0, 0);
      idle(2);

      // Clean frame with latency pinned on the first beat.
      frame(-1, -1, -1, -1, 1);
      idle(3);
      chk("A_frame_cnt", int'(frame_cnt), 1);
      chk("A_beats", beats, 32);
      chk("A_sof", sof_cnt, 1);
      chk("A_eol", eol_cnt, 4);
      chk("A_eof", eof_cnt, 1);
      chk("A_errors", int'({err_onehot, err_seq}), 0);

      // Frame B straight out of DONE, frame C after a scan_done rising edge.
      frame(-1, -1, -1, -1, 0);
      idle(3);
      drive('0, '0, 0, 1);
      drive('0, '0, 0, 1);
      drive('0, '0, 0, 0);
      frame(-1, -1, -1, -1, 0);
      idle(3);
      chk("C_frame_cnt", int'(frame_cnt), 3);
      chk("C_sof", sof_cnt, 3);

      // Multi-hot column before (1,2), dwell of 3 cycles on (1,3).
      b0 = beats; c13 = cnt13;
      frame(-1, 11, 10, -1, 0);
      idle(3);
      chk("D_err_onehot", int'(err_onehot), 1);
      chk("D_err_seq", int'(err_seq), 0);
      chk("D_dwell_one_beat", cnt13 - c13, 1);
      chk("D_beats", beats - b0, 32);
      chk("D_frame_cnt", int'(frame_cnt), 4);

      // Column 5 of row 2 skipped.
      b0 = beats;
      frame(21, -1, -1, -1, 0);
      idle(3);
      chk("E_err_seq", int'(err_seq), 1);
      chk("E_err_onehot_sticky", int'(err_onehot), 1);
      chk("E_beats", beats - b0, 31);
      chk("E_eof", eof_cnt, 5);
      chk("E_frame_cnt", int'(frame_cnt), 5);

      // Reset in place of (2,4), then a fresh frame.
      frame(-1, -1, -1, 20, 0);
      do_reset();
      frame(-1, -1, -1, -1, 0);
      chk("F_cnt_before_eof", int'(frame_cnt), 0);
      idle(3);
      chk("F_frame_cnt", int'(frame_cnt), 1);
      chk("F_sof", sof_cnt, 7);
      chk("F_errors", int'({err_onehot, err_seq}), 0);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
